// File: rtl/bg_vram_update_sched.sv
// Background VRAM write scheduler: buffers CPU writes and drains them to RAM
// only during vertical blanking; commits the scroll pointer once per frame.
//
// state | meaning
// IDLE  | outside a drain window; writes are buffered, RAM port quiet
// DRAIN | blanking window: popping FIFO entries into the RAM port within budget
module bg_vram_update_sched #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int DRAIN_MAX  = 64
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          frame_start,
  input  logic                          in_vblank,
  input  logic                          cpu_wr_valid,
  output logic                          cpu_wr_ready,
  input  logic [ADDR_W-1:0]             cpu_wr_addr,
  input  logic [DATA_W-1:0]             cpu_wr_data,
  input  logic                          scroll_wr_valid,
  input  logic [8:0]                    scroll_wr_val,
  output logic                          ram_we,
  output logic [ADDR_W-1:0]             ram_waddr,
  output logic [DATA_W-1:0]             ram_wdata,
  output logic [8:0]                    scroll_ptr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          scroll_err,
  output logic                          drain_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BUD_W = $clog2(DRAIN_MAX + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                     state, state_nxt;
  logic [ADDR_W+DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic [CNT_W-1:0]           count_nxt;
  logic [BUD_W-1:0]           budget;
  logic                       wrote_any;
  logic [8:0]                 pend_val;
  logic                       pending;
  logic                       push, pop, empty, start, done_nxt, scroll_legal;

  assign push      = cpu_wr_valid && cpu_wr_ready;
  assign empty     = (fifo_count == '0);
  assign count_nxt = fifo_count + CNT_W'(push) - CNT_W'(pop);
  // Rows 240..255 of each 256-word half are attribute words, not scroll rows.
  assign scroll_legal = (scroll_wr_val < 9'd240) ||
                        ((scroll_wr_val >= 9'd256) && (scroll_wr_val < 9'd496));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // A drain window ends as soon as no pop is possible: empty, vblank gone or budget spent.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = DRAIN;
      DRAIN:   if (!pop)        state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start    = 1'b0;
    pop      = 1'b0;
    done_nxt = 1'b0;
    case (state)
      IDLE:  start = frame_start;
      DRAIN: begin
        pop      = in_vblank && !empty && (budget != '0);
        done_nxt = empty && wrote_any;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cpu_wr_addr, cpu_wr_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      cpu_wr_ready <= 1'b1;
      ram_we       <= 1'b0;
      ram_waddr    <= '0;
      ram_wdata    <= '0;
      drain_done   <= 1'b0;
      budget       <= '0;
      wrote_any    <= 1'b0;
      scroll_ptr   <= '0;
      pend_val     <= '0;
      pending      <= 1'b0;
      scroll_err   <= 1'b0;
    end else begin
      fifo_count   <= count_nxt;
      cpu_wr_ready <= (count_nxt != FULL);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      ram_we     <= pop;
      if (pop) {ram_waddr, ram_wdata} <= mem[rd_ptr];
      drain_done <= done_nxt;
      if (start) begin
        budget    <= BUD_W'(DRAIN_MAX);
        wrote_any <= 1'b0;
      end else if (pop) begin
        budget    <= budget - 1'b1;
        wrote_any <= 1'b1;
      end
      if (start && pending) scroll_ptr <= pend_val;
      if (start) pending <= 1'b0;
      // Later in the block so a capture on the commit edge stays pending.
      if (scroll_wr_valid) begin
        if (scroll_legal) begin
          pend_val <= scroll_wr_val;
          pending  <= 1'b1;
        end else begin
          scroll_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bg_vram_update_sched.sv
// Bench for bg_vram_update_sched: queue-based reference of accepted writes,
// per-frame write count/order/timing predicted from buffer length, budget and vblank length.
module tb_bg_vram_update_sched;
  localparam int AW = 9;
  localparam int DW = 32;
  localparam int DEPTH = 16;
  localparam int DMAX = 64;

  logic clk = 0, rstn = 0, frame_start = 0, in_vblank = 0;
  logic cpu_wr_valid = 0, scroll_wr_valid = 0;
  logic [AW-1:0] cpu_wr_addr = '0;
  logic [DW-1:0] cpu_wr_data = '0;
  logic [8:0] scroll_wr_val = '0;
  logic cpu_wr_ready, ram_we, scroll_err, drain_done;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [8:0] scroll_ptr;
  logic [4:0] fifo_count;

  typedef struct {int cyc; logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  wr_t got_q[$];
  wr_t exp_q[$];
  int cyc = 0, dd_cnt = 0, n_checks = 0, n_fail = 0;

  bg_vram_update_sched #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .DRAIN_MAX(DMAX)) dut (
    .clk(clk), .rstn(rstn), .frame_start(frame_start), .in_vblank(in_vblank),
    .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
    .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .scroll_wr_valid(scroll_wr_valid), .scroll_wr_val(scroll_wr_val),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .scroll_ptr(scroll_ptr), .fifo_count(fifo_count),
    .scroll_err(scroll_err), .drain_done(drain_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wr_t w;
    if (ram_we) begin
      w.cyc = cyc; w.a = ram_waddr; w.d = ram_wdata;
      got_q.push_back(w);
    end
    if (drain_done) dd_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  // Called at a negedge; holds the request until the DUT accepts it.
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    wr_t w;
    cpu_wr_valid = 1; cpu_wr_addr = a; cpu_wr_data = d;
    while (!cpu_wr_ready && n < 2000) begin @(negedge clk); n++; end
    n_checks++;
    if (!cpu_wr_ready) begin
      n_fail++;
      $display("FAIL push_timeout ready=%0b required=1", cpu_wr_ready);
    end else begin
      w.cyc = 0; w.a = a; w.d = d;
      exp_q.push_back(w);
    end
    @(negedge clk);
    cpu_wr_valid = 0;
  endtask

  task automatic run_frame(input int v, output int fs);
    got_q.delete();
    fs = cyc; frame_start = 1; in_vblank = 1;
    @(negedge clk);
    frame_start = 0;
    repeat (v - 1) @(negedge clk);
    in_vblank = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic scroll_write(input logic [8:0] v);
    scroll_wr_valid = 1; scroll_wr_val = v;
    @(negedge clk);
    scroll_wr_valid = 0;
  endtask

  task automatic test_reset();
    int fs, dd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ram_we !== 0 || cpu_wr_ready !== 1 || fifo_count !== 0 || scroll_ptr !== 0 ||
        scroll_err !== 0 || drain_done !== 0 || ram_waddr !== 0 || ram_wdata !== 0) begin
      n_fail++;
      $display("FAIL reset_values we=%b rdy=%b cnt=%0d ptr=%0d err=%b dd=%b required 0 1 0 0 0 0",
               ram_we, cpu_wr_ready, fifo_count, scroll_ptr, scroll_err, drain_done);
    end
    rstn = 1;
    @(negedge clk);
    dd0 = dd_cnt;
    for (int f = 0; f < 3; f++) begin
      run_frame(20, fs);
      n_checks++;
      if (got_q.size() != 0 || scroll_ptr !== 0 || cpu_wr_ready !== 1 || fifo_count !== 0) begin
        n_fail++;
        $display("FAIL idle_frame%0d writes=%0d ptr=%0d rdy=%b cnt=%0d required 0 0 1 0",
                 f, got_q.size(), scroll_ptr, cpu_wr_ready, fifo_count);
      end
    end
    n_checks++;
    if (dd_cnt != dd0) begin
      n_fail++;
      $display("FAIL idle_drain_done pulses=%0d required=0", dd_cnt - dd0);
    end
  endtask

  task automatic test_basic_drain();
    int fs, dd0;
    int ta[5] = '{0, 1, 2, 240, 496};
    wr_t e;
    for (int i = 0; i < 5; i++) push(AW'(ta[i]), 32'h11111111 * (i + 1));
    n_checks++;
    if (fifo_count !== 5) begin n_fail++; $display("FAIL basic_fill cnt=%0d required=5", fifo_count); end
    dd0 = dd_cnt;
    run_frame(100, fs);
    n_checks++;
    if (got_q.size() != 5) begin n_fail++; $display("FAIL basic_count got=%0d required=5", got_q.size()); end
    foreach (got_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL basic_extra addr=%h required none", got_q[i].a);
      end else begin
        e = exp_q.pop_front();
        if (got_q[i].a !== e.a || got_q[i].d !== e.d || got_q[i].cyc != fs + 2 + i) begin
          n_fail++;
          $display("FAIL basic_wr%0d got cyc=%0d a=%h d=%h required cyc=%0d a=%h d=%h",
                   i, got_q[i].cyc, got_q[i].a, got_q[i].d, fs + 2 + i, e.a, e.d);
        end
      end
    end
    n_checks++;
    if (dd_cnt - dd0 != 1 || fifo_count !== 0) begin
      n_fail++; $display("FAIL basic_done pulses=%0d cnt=%0d required 1 0", dd_cnt - dd0, fifo_count);
    end
  endtask

  task automatic test_fifo_full();
    int fs, dd0;
    wr_t e;
    for (int i = 0; i < DEPTH; i++) push(AW'($urandom), $urandom);
    n_checks++;
    if (fifo_count !== 16 || cpu_wr_ready !== 0) begin
      n_fail++; $display("FAIL full_state cnt=%0d rdy=%b required 16 0", fifo_count, cpu_wr_ready);
    end
    dd0 = dd_cnt;
    fork
      push(9'h1AB, 32'hDEADBEEF);
      begin
        repeat (5) @(negedge clk);
        n_checks++;
        if (fifo_count !== 16 || cpu_wr_ready !== 0) begin
          n_fail++; $display("FAIL full_hold cnt=%0d rdy=%b required 16 0", fifo_count, cpu_wr_ready);
        end
        run_frame(100, fs);
      end
    join
    n_checks++;
    if (got_q.size() != 17) begin n_fail++; $display("FAIL full_count got=%0d required=17", got_q.size()); end
    foreach (got_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL full_extra addr=%h required none", got_q[i].a);
      end else begin
        e = exp_q.pop_front();
        if (got_q[i].a !== e.a || got_q[i].d !== e.d || got_q[i].cyc != fs + 2 + i) begin
          n_fail++;
          $display("FAIL full_wr%0d got cyc=%0d a=%h d=%h required cyc=%0d a=%h d=%h",
                   i, got_q[i].cyc, got_q[i].a, got_q[i].d, fs + 2 + i, e.a, e.d);
        end
      end
    end
    n_checks++;
    if (dd_cnt - dd0 != 1 || fifo_count !== 0 || cpu_wr_ready !== 1) begin
      n_fail++;
      $display("FAIL full_done pulses=%0d cnt=%0d rdy=%b required 1 0 1", dd_cnt - dd0, fifo_count, cpu_wr_ready);
    end
  endtask

  // Predicted writes per frame: min(buffered, budget, vblank cycles - 1).
  task automatic test_random_frames(input int iters, input string tag);
    int fs, dd0, ltot, v, exp_n, l;
    wr_t e;
    for (int it = 0; it < iters; it++) begin
      l = (exp_q.size() < DEPTH) ? $urandom_range(1, DEPTH - exp_q.size()) : 0;
      for (int i = 0; i < l; i++) push(AW'($urandom), $urandom);
      ltot = exp_q.size();
      if (ltot < 2 || $urandom_range(0, 1) == 0) v = 40;
      else v = $urandom_range(2, ltot);
      exp_n = (ltot < v - 1) ? ltot : v - 1;
      if (exp_n > DMAX) exp_n = DMAX;
      dd0 = dd_cnt;
      run_frame(v, fs);
      n_checks++;
      if (got_q.size() != exp_n) begin
        n_fail++; $display("FAIL %s%0d_count got=%0d required=%0d", tag, it, got_q.size(), exp_n);
      end
      foreach (got_q[i]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s%0d_extra addr=%h required none", tag, it, got_q[i].a);
        end else begin
          e = exp_q.pop_front();
          if (got_q[i].a !== e.a || got_q[i].d !== e.d || got_q[i].cyc != fs + 2 + i) begin
            n_fail++;
            $display("FAIL %s%0d_wr%0d got cyc=%0d a=%h d=%h required cyc=%0d a=%h d=%h",
                     tag, it, i, got_q[i].cyc, got_q[i].a, got_q[i].d, fs + 2 + i, e.a, e.d);
          end
        end
      end
      n_checks++;
      if (dd_cnt - dd0 != ((exp_n == ltot) ? 1 : 0) || fifo_count !== 5'(ltot - exp_n)) begin
        n_fail++;
        $display("FAIL %s%0d_done pulses=%0d cnt=%0d required %0d %0d", tag, it,
                 dd_cnt - dd0, fifo_count, (exp_n == ltot) ? 1 : 0, ltot - exp_n);
      end
    end
  endtask

  task automatic test_vblank_drop();
    int fs, dd0;
    wr_t e;
    for (int i = 0; i < 8; i++) push(AW'(i * 37), 32'hA0000000 + i);
    for (int f = 0; f < 2; f++) begin
      dd0 = dd_cnt;
      run_frame(f == 0 ? 4 : 100, fs);
      n_checks++;
      if (got_q.size() != (f == 0 ? 3 : 5)) begin
        n_fail++; $display("FAIL drop%0d_count got=%0d required=%0d", f, got_q.size(), f == 0 ? 3 : 5);
      end
      foreach (got_q[i]) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL drop%0d_extra addr=%h required none", f, got_q[i].a);
        end else begin
          e = exp_q.pop_front();
          if (got_q[i].a !== e.a || got_q[i].d !== e.d || got_q[i].cyc != fs + 2 + i) begin
            n_fail++;
            $display("FAIL drop%0d_wr%0d got cyc=%0d a=%h d=%h required cyc=%0d a=%h d=%h",
                     f, i, got_q[i].cyc, got_q[i].a, got_q[i].d, fs + 2 + i, e.a, e.d);
          end
        end
      end
      n_checks++;
      if (dd_cnt - dd0 != f || fifo_count !== (f == 0 ? 5'd5 : 5'd0)) begin
        n_fail++;
        $display("FAIL drop%0d_done pulses=%0d cnt=%0d required %0d %0d", f, dd_cnt - dd0, fifo_count, f, f == 0 ? 5 : 0);
      end
    end
  endtask

  // Continuous pushes during blanking keep the FIFO busy so only the budget stops the drain.
  task automatic test_budget();
    int fs, dd0;
    wr_t e;
    for (int i = 0; i < DEPTH; i++) push(AW'($urandom), $urandom);
    dd0 = dd_cnt;
    fork
      for (int i = 0; i < 60; i++) push(AW'($urandom), $urandom);
      run_frame(150, fs);
    join
    n_checks++;
    if (got_q.size() != DMAX) begin n_fail++; $display("FAIL budget_count got=%0d required=%0d", got_q.size(), DMAX); end
    foreach (got_q[i]) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL budget_extra addr=%h required none", got_q[i].a);
      end else begin
        e = exp_q.pop_front();
        if (got_q[i].a !== e.a || got_q[i].d !== e.d || got_q[i].cyc != fs + 2 + i) begin
          n_fail++;
          $display("FAIL budget_wr%0d got cyc=%0d a=%h d=%h required cyc=%0d a=%h d=%h",
                   i, got_q[i].cyc, got_q[i].a, got_q[i].d, fs + 2 + i, e.a, e.d);
        end
      end
    end
    n_checks++;
    if (dd_cnt != dd0 || fifo_count !== 5'(16 + 60 - DMAX)) begin
      n_fail++; $display("FAIL budget_left pulses=%0d cnt=%0d required 0 %0d", dd_cnt - dd0, fifo_count, 16 + 60 - DMAX);
    end
    test_random_frames(1, "budget_tail");
  endtask

  task automatic test_scroll();
    int fs;
    logic [8:0] m_ptr, m_pend, v;
    bit m_has, m_err;
    scroll_write(9'd100);
    scroll_write(9'd300);
    run_frame(10, fs);
    n_checks++;
    if (scroll_ptr !== 9'd300 || scroll_err !== 0) begin
      n_fail++; $display("FAIL scroll_commit ptr=%0d err=%b required 300 0", scroll_ptr, scroll_err);
    end
    run_frame(10, fs);
    n_checks++;
    if (scroll_ptr !== 9'd300) begin n_fail++; $display("FAIL scroll_once ptr=%0d required 300", scroll_ptr); end
    scroll_write(9'd200);
    scroll_wr_valid = 1; scroll_wr_val = 9'd400; frame_start = 1; in_vblank = 1;
    @(negedge clk);
    scroll_wr_valid = 0; frame_start = 0;
    repeat (5) @(negedge clk);
    in_vblank = 0;
    @(negedge clk);
    n_checks++;
    if (scroll_ptr !== 9'd200) begin n_fail++; $display("FAIL scroll_same_edge ptr=%0d required 200", scroll_ptr); end
    run_frame(10, fs);
    n_checks++;
    if (scroll_ptr !== 9'd400) begin n_fail++; $display("FAIL scroll_deferred ptr=%0d required 400", scroll_ptr); end
    scroll_write(9'd250);
    n_checks++;
    if (scroll_err !== 1 || scroll_ptr !== 9'd400) begin
      n_fail++; $display("FAIL scroll_illegal err=%b ptr=%0d required 1 400", scroll_err, scroll_ptr);
    end
    run_frame(10, fs);
    n_checks++;
    if (scroll_ptr !== 9'd400) begin n_fail++; $display("FAIL scroll_ignored ptr=%0d required 400", scroll_ptr); end
    m_ptr = 9'd400; m_has = 0; m_err = 1; m_pend = 0;
    for (int i = 0; i < 18; i++) begin
      v = 9'($urandom_range(0, 511));
      scroll_write(v);
      if ((v % 256) < 240) begin m_pend = v; m_has = 1; end
      else m_err = 1;
      if (i % 3 == 2) begin
        run_frame(6, fs);
        if (m_has) begin m_ptr = m_pend; m_has = 0; end
        n_checks++;
        if (scroll_ptr !== m_ptr || scroll_err !== m_err) begin
          n_fail++;
          $display("FAIL scroll_rand%0d ptr=%0d err=%b required %0d %b", i, scroll_ptr, scroll_err, m_ptr, m_err);
        end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int fs, n = 0;
    for (int i = 0; i < 8; i++) push(AW'($urandom), $urandom);
    scroll_write(9'd123);
    got_q.delete();
    frame_start = 1; in_vblank = 1;
    @(negedge clk);
    frame_start = 0;
    scroll_write(9'd77);
    while (got_q.size() < 3 && n < 50) begin @(negedge clk); n++; end
    n_checks++;
    if (got_q.size() < 3) begin n_fail++; $display("FAIL rst_drain_start writes=%0d required>=3", got_q.size()); end
    rstn = 0;
    #1;
    n_checks++;
    if (ram_we !== 0 || cpu_wr_ready !== 1 || fifo_count !== 0 || scroll_ptr !== 0 ||
        scroll_err !== 0 || drain_done !== 0 || ram_waddr !== 0 || ram_wdata !== 0) begin
      n_fail++;
      $display("FAIL rst_async we=%b rdy=%b cnt=%0d ptr=%0d err=%b dd=%b required 0 1 0 0 0 0",
               ram_we, cpu_wr_ready, fifo_count, scroll_ptr, scroll_err, drain_done);
    end
    in_vblank = 0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1;
    @(negedge clk);
    run_frame(30, fs);
    n_checks++;
    if (got_q.size() != 0 || scroll_ptr !== 0 || fifo_count !== 0) begin
      n_fail++;
      $display("FAIL rst_discard writes=%0d ptr=%0d cnt=%0d required 0 0 0", got_q.size(), scroll_ptr, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_fifo_full();
    test_vblank_drop();
    test_budget();
    test_random_frames(8, "rand");
    test_random_frames(1, "flush");
    test_scroll();
    test_reset_mid_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
